fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 38 +++
 rtl/tick_gen.sv | 28 ++
 rtl/fnd_scan_ctrl.sv | 99 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared slot encoding and constants for the FND scan controller and anode decoder.
// Slots 0-3 carry the four digits; slot 4 is the dot slot routed to digit 2.
package fnd_pkg;

  localparam int SEL_W     = 3;
  localparam int NUM_SLOTS = 5;

  typedef logic [SEL_W-1:0] slot_t;

  localparam slot_t SLOT_DIG0 = 3'd0;
  localparam slot_t SLOT_DIG1 = 3'd1;
  localparam slot_t SLOT_DIG2 = 3'd2;
  localparam slot_t SLOT_DIG3 = 3'd3;
  localparam slot_t SLOT_DOT  = 3'd4;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Unreachable codes 5-7 fall into the wrap branch, so a corrupted slot self-heals.
  function automatic slot_t next_slot(input slot_t s);
    slot_t r;
    if (s >= SLOT_DOT) r = SLOT_DIG0;
    else               r = s + 3'd1;
    return r;
  endfunction

  function automatic logic [3:0] digit_nibble(input logic [15:0] d, input slot_t s);
    logic [3:0] r;
    case (s)
      SLOT_DIG0: r = d[3:0];
      SLOT_DIG1: r = d[7:4];
      SLOT_DIG2: r = d[11:8];
      SLOT_DIG3: r = d[15:12];
      default:   r = BCD_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-clk tick every DIV clocks, count wraps to 0 on the tick edge.
// Tick is decoded from the count register; free-running, no backpressure.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "tick_gen: DIV must be at least 2");
  end

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 5-slot FND scan (4 digits + blinking dot slot) producing fnd_sel, bcd and dp_n.
// All outputs registered from next-state slot: 1 clk input-to-output; free-running, no backpressure.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      digit_data,
  input  logic             blink_en,
  output logic [SEL_W-1:0] fnd_sel,
  output logic [3:0]       bcd,
  output logic             dp_n
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (HALF < 1) begin : g_bad_half
    $fatal(1, "fnd_scan_ctrl: SCAN_HZ/(2*BLINK_HZ) must be at least 1");
  end

  logic          w_tick;
  slot_t         r_slot;
  slot_t         w_slot_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;
  logic          r_dot_phase;
  logic          w_phase_nxt;
  logic [3:0]    w_bcd_nxt;
  logic          w_dp_n_nxt;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= SLOT_DIG0;
      r_blink_cnt <= '0;
      r_dot_phase <= 1'b0;
    end else begin
      r_slot      <= w_slot_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_dot_phase <= w_phase_nxt;
    end
  end

  // Blink counter free-runs on every tick so enabling the dot never restarts its phase.
  always_comb begin
    w_slot_nxt  = r_slot;
    w_blink_nxt = r_blink_cnt;
    w_phase_nxt = r_dot_phase;
    if (w_tick) begin
      w_slot_nxt = next_slot(r_slot);
      if (r_blink_cnt == HALF_LAST) begin
        w_blink_nxt = '0;
        w_phase_nxt = ~r_dot_phase;
      end else begin
        w_blink_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_bcd_nxt  = BCD_BLANK;
    w_dp_n_nxt = 1'b1;
    if (w_slot_nxt == SLOT_DOT) begin
      w_dp_n_nxt = ~(blink_en & w_phase_nxt);
    end else begin
      w_bcd_nxt = digit_nibble(digit_data, w_slot_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fnd_sel <= SLOT_DIG0;
      bcd     <= 4'h0;
      dp_n    <= 1'b1;
    end else begin
      fnd_sel <= w_slot_nxt;
      bcd     <= w_bcd_nxt;
      dp_n    <= w_dp_n_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized bench for fnd_scan_ctrl against an edge-count arithmetic model.
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ   = 100;
  localparam int SCAN_HZ  = 10;
  localparam int BLINK_HZ = 1;
  localparam int DIV      = CLK_HZ / SCAN_HZ;
  localparam int HALF     = SCAN_HZ / (2 * BLINK_HZ);
  localparam int NSLOT    = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digit_data;
  logic        blink_en;
  logic [2:0]  fnd_sel;
  logic [3:0]  bcd;
  logic        dp_n;

  int n_edges;
  int vectors;
  int miscompares;

  fnd_scan_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .blink_en   (blink_en),
    .fnd_sel    (fnd_sel),
    .bcd        (bcd),
    .dp_n       (dp_n)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d, t=%0t)", tag, obs, exp, n_edges, $time);
    end
  endtask

  // Reference: after n edges since release, n/DIV ticks have occurred.
  function automatic int m_slot(input int n);
    return (n / DIV) % NSLOT;
  endfunction

  function automatic int m_phase(input int n);
    return ((n / DIV) / HALF) % 2;
  endfunction

  task automatic check_model();
    int s;
    int exp_bcd;
    int exp_dp;
    s = m_slot(n_edges);
    if (s < 4) begin
      exp_bcd = (int'(digit_data) >> (4 * s)) & 15;
      exp_dp  = 1;
    end else begin
      exp_bcd = 15;
      exp_dp  = (blink_en && m_phase(n_edges) == 1) ? 0 : 1;
    end
    expect_eq("fnd_sel", 32'(fnd_sel), 32'(s));
    expect_eq("bcd",     32'(bcd),     32'(exp_bcd));
    expect_eq("dp_n",    32'(dp_n),    32'(exp_dp));
  endtask

  task automatic step(input bit do_model);
    @(posedge clk);
    n_edges++;
    #1;
    expect_eq("sel_range", 32'(fnd_sel <= 3'd4), 32'd1);
    if (do_model) check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    expect_eq({tag, "_sel"}, 32'(fnd_sel), 32'd0);
    expect_eq({tag, "_bcd"}, 32'(bcd),     32'd0);
    expect_eq({tag, "_dp"},  32'(dp_n),    32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    n_edges = 0;
  endtask

  task automatic run_until(input int want_slot, input int want_cnt, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_slot(n_edges) == want_slot && (n_edges % DIV) == want_cnt) hit = 1'b1;
      else step(1'b1);
    end
    if (!hit) expect_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_edges     = 0;
    rst_n       = 1'b0;
    digit_data  = 16'h1234;
    blink_en    = 1'b0;

    #12;
    check_reset_vals("rst0");
    release_reset();

    // Basic scan with dot disabled.
    for (int i = 0; i < 60; i++) step(1'b1);

    // Blinking dot across 30 slot-4 visits, with occasional digit changes.
    blink_en = 1'b1;
    for (int i = 0; i < 30 * NSLOT * DIV; i++) begin
      step(1'b1);
      if ($urandom_range(7) == 0) digit_data = 16'($urandom);
    end

    // Random blink_en toggling: phase must track the free-running counter.
    for (int i = 0; i < 1000; i++) begin
      step(1'b1);
      if ($urandom_range(15) == 0) blink_en = ~blink_en;
      if ($urandom_range(9) == 0)  digit_data = 16'($urandom);
    end

    // Digit change while slot 1 is active.
    digit_data = 16'h1234;
    run_until(1, 3, "dchg");
    digit_data = 16'h9876;
    step(1'b1);
    expect_eq("dchg_bcd", 32'(bcd),     32'd7);
    expect_eq("dchg_sel", 32'(fnd_sel), 32'd1);

    // Asynchronous reset mid-slot.
    run_until(3, 7, "arst");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    release_reset();
    for (int i = 0; i < DIV - 1; i++) begin
      step(1'b1);
      expect_eq("hold_slot0", 32'(fnd_sel), 32'd0);
    end
    step(1'b1);
    expect_eq("first_tick_sel", 32'(fnd_sel), 32'd1);

    // Corrupt slot to 6 just before a tick; it must recover to 0.
    run_until(2, DIV - 1, "force");
    dut.r_slot = 3'd6;
    digit_data = 16'hA5C3;
    step(1'b0);
    expect_eq("force_sel", 32'(fnd_sel), 32'd0);
    expect_eq("force_bcd", 32'(bcd),     32'h3);
    expect_eq("force_dp",  32'(dp_n),    32'd1);

    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_end");
    release_reset();
    for (int i = 0; i < 3 * NSLOT * DIV; i++) begin
      step(1'b1);
      if ($urandom_range(5) == 0) digit_data = 16'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
